iiitb_univ_shreg: RTL and testbench

IIITB_UNIV_SHREG -- requirements
Module: iiitb_univ_shreg

---
 rtl/iiitb_univ_shreg.sv | 119 +++++++++++
 tb/tb_iiitb_univ_shreg.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/iiitb_univ_shreg.sv
// iiitb_univ_shreg: universal shift register with word-completion pulse.
//
// Purpose:
//   A WIDTH-bit register that can hold, shift right, shift left or load in
//   parallel. A shift counter tracks progress through a word. Each time WIDTH
//   shifts complete, done pulses high for one cycle. Left and right shifts
//   count alike.
//
// Ports:
//   clk      in   rising-edge clock
//   clear_n  in   asynchronous active-low reset (po, cnt and done go to 0)
//   sclr     in   synchronous clear, active-high; it has priority over mode
//   mode     in   2'b00 hold, 2'b01 shift right, 2'b10 shift left,
//                 2'b11 parallel load
//   pi       in   parallel data in [WIDTH-1:0]
//   si_r     in   serial in, enters at the MSB on a right shift
//   si_l     in   serial in, enters at the LSB on a left shift
//   po       out  register contents, straight from flops [WIDTH-1:0]
//   so_r     out  po[0]
//   so_l     out  po[WIDTH-1]
//   done     out  registered one-cycle pulse on the shift that completes a word
//
// Configuration:
//   IIITB_UNIV_SHREG_ROTATE_EN - when defined, shifts rotate the register and
//   the si_r/si_l inputs are ignored. Counter and done behaviour are the same.
module iiitb_univ_shreg #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             clear_n,
    input  logic             sclr,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] pi,
    input  logic             si_r,
    input  logic             si_l,
    output logic [WIDTH-1:0] po,
    output logic             so_r,
    output logic             so_l,
    output logic             done
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    localparam logic [1:0] MODE_HOLD  = 2'b00;
    localparam logic [1:0] MODE_RIGHT = 2'b01;
    localparam logic [1:0] MODE_LEFT  = 2'b10;
    localparam logic [1:0] MODE_LOAD  = 2'b11;

    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] shift_next;

`ifdef IIITB_UNIV_SHREG_ROTATE_EN
    // The serial inputs stay on the port list but play no part in rotation.
    logic unused_serial;
    assign unused_serial = si_r ^ si_l;
`endif

    // Value the register takes when a shift happens on this edge.
    always_comb begin
        shift_next = po;
        if (mode == MODE_RIGHT) begin
`ifdef IIITB_UNIV_SHREG_ROTATE_EN
            shift_next = {po[0], po[WIDTH-1:1]};
`else
            shift_next = {si_r, po[WIDTH-1:1]};
`endif
        end else if (mode == MODE_LEFT) begin
`ifdef IIITB_UNIV_SHREG_ROTATE_EN
            shift_next = {po[WIDTH-2:0], po[WIDTH-1]};
`else
            shift_next = {po[WIDTH-2:0], si_l};
`endif
        end
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            po   <= '0;
            cnt  <= '0;
            done <= 1'b0;
        end else begin
            // done is high only on the edge that wraps the counter.
            done <= 1'b0;
            if (sclr) begin
                po  <= '0;
                cnt <= '0;
            end else begin
                case (mode)
                    MODE_LOAD: begin
                        po  <= pi;
                        cnt <= '0;
                    end
                    MODE_RIGHT, MODE_LEFT: begin
                        po <= shift_next;
                        if (cnt == CNT_LAST) begin
                            cnt  <= '0;
                            done <= 1'b1;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    MODE_HOLD: begin
                        po  <= po;
                        cnt <= cnt;
                    end
                    default: begin
                        po  <= po;
                        cnt <= cnt;
                    end
                endcase
            end
        end
    end

    assign so_r = po[0];
    assign so_l = po[WIDTH-1];

endmodule

// File: tb/tb_iiitb_univ_shreg.sv
// Scoreboard bench for iiitb_univ_shreg. Each stimulus step pushes the
// hand-computed register state expected after the next rising edge. A monitor
// pops that state on the falling edge and compares it with the outputs.
module tb_iiitb_univ_shreg;

`ifdef IIITB_UNIV_SHREG_ROTATE_EN
    localparam int W = 8;
`else
    localparam int W = 4;
`endif

    logic         clk = 1'b0;
    logic         clear_n;
    logic         sclr;
    logic [1:0]   mode;
    logic [W-1:0] pi;
    logic         si_r;
    logic         si_l;
    logic [W-1:0] po;
    logic         so_r;
    logic         so_l;
    logic         done;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [W-1:0] po;
        logic         done;
        string        name;
    } exp_t;

    exp_t sb[$];

    iiitb_univ_shreg #(.WIDTH(W)) dut (
        .clk     (clk),
        .clear_n (clear_n),
        .sclr    (sclr),
        .mode    (mode),
        .pi      (pi),
        .si_r    (si_r),
        .si_l    (si_l),
        .po      (po),
        .so_r    (so_r),
        .so_l    (so_l),
        .done    (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: compare the outputs against the oldest pending expectation.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check({e.name, ".po"},   64'(po),   64'(e.po));
            check({e.name, ".so_r"}, 64'(so_r), 64'(e.po[0]));
            check({e.name, ".so_l"}, 64'(so_l), 64'(e.po[W-1]));
            check({e.name, ".done"}, 64'(done), 64'(e.done));
        end
    end

    // Drive one cycle of inputs and record the state expected after the edge.
    task automatic step(input logic cn, input logic sc, input logic [1:0] m,
                        input logic [W-1:0] p, input logic sr, input logic sl,
                        input logic [W-1:0] epo, input logic edone, input string name);
        @(negedge clk);
        #1;
        clear_n = cn;
        sclr    = sc;
        mode    = m;
        pi      = p;
        si_r    = sr;
        si_l    = sl;
        sb.push_back('{po: epo, done: edone, name: name});
    endtask

    // Apply reset while clk is high and check the outputs clear before the next edge.
    task automatic async_reset(input string name);
        @(negedge clk);
        #1;
        mode = 2'b00;
        sclr = 1'b0;
        @(posedge clk);
        #2;
        clear_n = 1'b0;
        #1;
        check({name, ".po"},   64'(po),   64'(0));
        check({name, ".done"}, 64'(done), 64'(0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_n = 1'b0;
        sclr    = 1'b0;
        mode    = 2'b11;
        pi      = '1;
        si_r    = 1'b0;
        si_l    = 1'b0;
        #1;
        check("reset0.po",   64'(po),   64'(0));
        check("reset0.done", 64'(done), 64'(0));

        // Held in reset with load requested: nothing must change.
        step(0, 0, 2'b11, '1, 0, 0, '0, 0, "rst_hold0");
        step(0, 0, 2'b11, '1, 0, 0, '0, 0, "rst_hold1");
        step(0, 0, 2'b11, '1, 0, 0, '0, 0, "rst_hold2");

`ifdef IIITB_UNIV_SHREG_ROTATE_EN
        step(1, 0, 2'b11, 8'hFF, 0, 0, 8'hFF, 0, "rel_load");
        // Load 8'h81 and rotate right 8 times; the serial inputs are ignored.
        step(1, 0, 2'b11, 8'h81, 0, 1, 8'h81, 0, "rot_load");
        step(1, 0, 2'b01, 8'h00, 0, 1, 8'hC0, 0, "rot_r1");
        step(1, 0, 2'b01, 8'h00, 0, 1, 8'h60, 0, "rot_r2");
        step(1, 0, 2'b01, 8'h00, 0, 1, 8'h30, 0, "rot_r3");
        step(1, 0, 2'b01, 8'h00, 0, 1, 8'h18, 0, "rot_r4");
        step(1, 0, 2'b01, 8'h00, 0, 1, 8'h0C, 0, "rot_r5");
        step(1, 0, 2'b01, 8'h00, 0, 1, 8'h06, 0, "rot_r6");
        step(1, 0, 2'b01, 8'h00, 0, 1, 8'h03, 0, "rot_r7");
        step(1, 0, 2'b01, 8'h00, 0, 1, 8'h81, 1, "rot_r8");
        step(1, 0, 2'b00, 8'h00, 0, 1, 8'h81, 0, "rot_hold");
        // Rotating left moves the MSB back in at the LSB.
        step(1, 0, 2'b10, 8'h00, 1, 0, 8'h03, 0, "rot_l1");
        step(1, 0, 2'b10, 8'h00, 1, 0, 8'h06, 0, "rot_l2");
`else
        step(1, 0, 2'b11, 4'hF, 0, 0, 4'hF, 0, "rel_load");

        // Load 1011, then shift right four times with si_r=0.
        step(1, 0, 2'b11, 4'b1011, 0, 0, 4'b1011, 0, "r_load");
        step(1, 0, 2'b01, 4'h0,    0, 0, 4'b0101, 0, "r1");
        step(1, 0, 2'b01, 4'h0,    0, 0, 4'b0010, 0, "r2");
        step(1, 0, 2'b01, 4'h0,    0, 0, 4'b0001, 0, "r3");
        step(1, 0, 2'b01, 4'h0,    0, 0, 4'b0000, 1, "r4");
        step(1, 0, 2'b00, 4'h0,    0, 0, 4'b0000, 0, "r_after");

        // Load 0001, then shift left four times with si_l=1.
        step(1, 0, 2'b11, 4'b0001, 0, 1, 4'b0001, 0, "l_load");
        step(1, 0, 2'b10, 4'h0,    0, 1, 4'b0011, 0, "l1");
        step(1, 0, 2'b10, 4'h0,    0, 1, 4'b0111, 0, "l2");
        step(1, 0, 2'b10, 4'h0,    0, 1, 4'b1111, 0, "l3");
        step(1, 0, 2'b10, 4'h0,    0, 1, 4'b1111, 1, "l4");
        step(1, 0, 2'b00, 4'h0,    0, 1, 4'b1111, 0, "l_after");

        // A reload mid-word restarts the count. Mixed directions count alike.
        step(1, 0, 2'b11, 4'b0101, 0, 0, 4'b0101, 0, "m_load1");
        step(1, 0, 2'b01, 4'h0,    0, 0, 4'b0010, 0, "m_s1");
        step(1, 0, 2'b01, 4'h0,    0, 0, 4'b0001, 0, "m_s2");
        step(1, 0, 2'b11, 4'hA,    0, 0, 4'b1010, 0, "m_load2");
        step(1, 0, 2'b01, 4'h0,    1, 0, 4'b1101, 0, "m_s3");
        step(1, 0, 2'b10, 4'h0,    0, 0, 4'b1010, 0, "m_s4");
        step(1, 0, 2'b01, 4'h0,    0, 0, 4'b0101, 0, "m_s5");
        step(1, 0, 2'b10, 4'h0,    0, 1, 4'b1011, 1, "m_s6");
        // A load right after the wrap still shows the pulse already registered.
        step(1, 0, 2'b11, 4'h6,    0, 0, 4'h6,    0, "m_load3");

        // sclr beats load; the count restarts from zero.
        step(1, 1, 2'b11, 4'hF,    0, 0, 4'h0,    0, "sclr_load");
        step(1, 0, 2'b10, 4'h0,    0, 1, 4'b0001, 0, "c_s1");
        step(1, 0, 2'b10, 4'h0,    0, 1, 4'b0011, 0, "c_s2");
        step(1, 1, 2'b01, 4'h0,    1, 0, 4'b0000, 0, "sclr_shift");
        step(1, 0, 2'b01, 4'h0,    1, 0, 4'b1000, 0, "c_s3");
        step(1, 0, 2'b01, 4'h0,    1, 0, 4'b1100, 0, "c_s4");
        step(1, 0, 2'b01, 4'h0,    1, 0, 4'b1110, 0, "c_s5");
        step(1, 0, 2'b01, 4'h0,    1, 0, 4'b1111, 1, "c_s6");

        // Hold leaves both data and count untouched.
        step(1, 0, 2'b11, 4'b1001, 0, 0, 4'b1001, 0, "h_load");
        step(1, 0, 2'b01, 4'h0,    0, 0, 4'b0100, 0, "h_s1");
        step(1, 0, 2'b00, 4'hF,    1, 1, 4'b0100, 0, "h_hold1");
        step(1, 0, 2'b00, 4'hF,    1, 1, 4'b0100, 0, "h_hold2");
        step(1, 0, 2'b01, 4'h0,    0, 0, 4'b0010, 0, "h_s2");
        step(1, 0, 2'b01, 4'h0,    0, 0, 4'b0001, 0, "h_s3");
        step(1, 0, 2'b01, 4'h0,    0, 0, 4'b0000, 1, "h_s4");

        // Asynchronous reset mid-word discards progress.
        step(1, 0, 2'b11, 4'hC,    0, 0, 4'hC,    0, "a_load");
        step(1, 0, 2'b10, 4'h0,    0, 0, 4'b1000, 0, "a_s1");
        async_reset("async_mid");
        step(1, 0, 2'b01, 4'h0,    1, 0, 4'b1000, 0, "a_s2");
        step(1, 0, 2'b01, 4'h0,    1, 0, 4'b1100, 0, "a_s3");
        step(1, 0, 2'b01, 4'h0,    1, 0, 4'b1110, 0, "a_s4");
        step(1, 0, 2'b01, 4'h0,    1, 0, 4'b1111, 1, "a_s5");
`endif

        @(negedge clk);
        #1;
        mode = 2'b00;
        @(negedge clk);
        #2;
        check("sb_drained", 64'(sb.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
